mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the CPU. Each port issues level requests; the block arbitrates, sequences one memory transaction at a time over a req/ack handshake, returns read data, and drives a stall to the PC and pipeline while any request is outstanding. A timeout counter aborts transactions the memory never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for mem_ack; 0 disables timeout

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_gnt  out  1  one-cycle pulse: fetch launched
- if_valid  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  fetched instruction, registered
- dm_req  in  1  data request, level, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse: data access launched
- dm_valid  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DATA_W  load data, registered
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- bus_err  out  1  one-cycle pulse: transaction timed out
- cpu_stall  out  1  combinational: (if_req & ~if_valid) | (dm_req & ~dm_valid)

## Operation
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE: eligible requester = req high and its valid not high this cycle (masks the stale req in the completion cycle). One eligible -> grant it. Both -> priority rule (Configuration).
- On grant: register addr/we/wdata into mem_* (fetch: mem_we=0, mem_wdata=0); assert mem_req and gnt pulse next cycle; enter the BUSY state; clear timeout counter.
- BUSY: mem_req and mem_* held constant; counter increments each cycle without ack.
- mem_ack in BUSY: drop mem_req next cycle, pulse the port's valid, capture mem_rdata into port rdata for reads only (rdata holds for writes), return to IDLE.
- Timeout (TIMEOUT != 0, counter reaches TIMEOUT with no ack): drop mem_req, pulse valid and bus_err, port rdata <= 0, return to IDLE.
- Ack and timeout in same cycle: ack wins, no bus_err.
- mem_ack in IDLE ignored.
- Requests dropped before grant are never served; req dropping during BUSY does not cancel the transaction.
- Reset values: all outputs 0, state IDLE, counter 0, rdata registers 0. Reset mid-transaction: mem_req drops immediately, transaction discarded, no valid.

## Timing
- Req high at edge N in IDLE -> gnt, mem_req at N+1.
- mem_ack at edge K -> valid, rdata, mem_req=0, IDLE at K+1.
- Earliest next grant: mem_req at K+2 (one idle cycle between transactions).
- Zero-wait memory (ack in first mem_req cycle): 3 cycles per access back-to-back.
- Timeout: mem_req high for exactly TIMEOUT cycles; bus_err at the following edge.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on tie grant the port not granted last; last-grant pointer resets to IF so first tie goes to data.
- Undefined: fixed priority, data port always wins ties.

## Test plan
- Single fetch, if_addr=0x40, ack after 2 cycles with 0x00A00093 -> if_gnt at N+1, if_valid and if_rdata=0x00A00093 at N+4, cpu_stall low after valid.
- Store dm_addr=0x100, wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held until ack; dm_rdata unchanged.
- Simultaneous if_req and dm_req, zero-wait memory -> data served first; without macro, continuous dm_req starves fetch; with MEM_ARB_RR_EN, grants alternate DM, IF, DM.
- No ack, TIMEOUT=4 -> mem_req high 4 cycles, bus_err and dm_valid pulse, dm_rdata=0, next request granted normally.
- mem_ack coincident with timeout cycle -> valid with mem_rdata, bus_err stays 0.
- reset_n low while DM_BUSY -> mem_req low immediately, no dm_valid; after release, pending req granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for one single-ported memory with ack timeout.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default build lets data win ties.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bus_err,
   output logic              cpu_stall
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;
   state_t state, next_state;
   logic [CW-1:0] cnt;
   logic if_elig, dm_elig, grant_if, grant_dm, timed_out, done;
`ifdef MEM_ARB_RR_EN
   logic last_dm;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) last_dm <= 1'b0;
      else if (grant_dm | grant_if) last_dm <= grant_dm;
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= next_state;
   always_comb
      next_state = (state == IDLE) ? (grant_dm ? DM_BUSY : grant_if ? IF_BUSY : IDLE) :
                   done ? IDLE : state;
   // A port's req is still high in its own valid cycle; that stale level must not re-grant.
   always_comb begin
      if_elig = if_req & ~if_valid;
      dm_elig = dm_req & ~dm_valid;
`ifdef MEM_ARB_RR_EN
      grant_dm = (state == IDLE) & dm_elig & (~if_elig | ~last_dm);
`else
      grant_dm = (state == IDLE) & dm_elig;
`endif
      grant_if = (state == IDLE) & if_elig & ~grant_dm;
      timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1)) && !mem_ack;
      done = (state != IDLE) && (mem_ack || timed_out);
      mem_req = state != IDLE;
      cpu_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {if_gnt, dm_gnt, if_valid, dm_valid, bus_err, mem_we} <= '0;
         mem_addr <= '0;
         mem_wdata <= '0;
         if_rdata <= '0;
         dm_rdata <= '0;
         cnt <= '0;
      end else begin
         if_gnt <= grant_if;
         dm_gnt <= grant_dm;
         if_valid <= done && state == IF_BUSY;
         dm_valid <= done && state == DM_BUSY;
         bus_err <= done && !mem_ack;
         if (grant_dm | grant_if) begin
            mem_addr <= grant_dm ? dm_addr : if_addr;
            mem_we <= grant_dm & dm_we;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            cnt <= '0;
         end else if (state != IDLE) cnt <= cnt + 1'b1;
         if (done && state == IF_BUSY) if_rdata <= mem_ack ? mem_rdata : '0;
         if (done && state == DM_BUSY && (!mem_ack || !mem_we)) dm_rdata <= mem_ack ? mem_rdata : '0;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; expected grants and completions are queued at issue
// and popped by a monitor whenever the arbiter pulses gnt or valid.
module tb_mem_arbiter;
   localparam int TO = 4;
   logic clk = 0, reset_n = 0;
   logic if_gnt, if_valid, dm_gnt, dm_valid, mem_req, mem_we, bus_err, cpu_stall;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, rd_val = 0;
   logic dm_we = 0, mem_ack = 0, if_req, dm_req;
   int if_issued = 0, if_done = 0, dm_issued = 0, dm_done = 0;
   int ack_wait = 0, wcnt = 0, run = 0, last_len = 0, total = 0, bad = 0;

   typedef struct packed {logic dm; logic [31:0] addr; logic we; logic [31:0] wdata;} gnt_t;
   typedef struct packed {logic dm; logic [31:0] rdata; logic err;} rsp_t;
   gnt_t gq[$];
   rsp_t rq[$];
   gnt_t g_m;
   rsp_t r_m;
   logic [31:0] h_addr, h_wdata;
   logic h_we;

   assign if_req = if_issued != if_done;
   assign dm_req = dm_issued != dm_done;
   assign mem_rdata = rd_val;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err), .cpu_stall(cpu_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_g(logic dm, logic [31:0] a, logic we, logic [31:0] wd);
      gq.push_back('{dm, a, we, wd});
   endtask

   task automatic push_r(logic dm, logic [31:0] d, logic err);
      rq.push_back('{dm, d, err});
   endtask

   task automatic start_dm(logic [31:0] a, logic we, logic [31:0] wd);
      dm_addr = a;
      dm_we = we;
      dm_wdata = wd;
      dm_issued++;
   endtask

   task automatic start_if(logic [31:0] a);
      if_addr = a;
      if_issued++;
   endtask

   task automatic wait_done(int budget);
      int n = 0;
      while ((gq.size() != 0 || rq.size() != 0 || mem_req || if_req || dm_req) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_budget", 64'(n < budget), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   // Memory model: ack after ack_wait extra cycles of mem_req; negative means never.
   always @(negedge clk) begin
      if (!mem_req) begin
         wcnt = 0;
         mem_ack = 0;
      end else begin
         mem_ack = (ack_wait >= 0) && (wcnt == ack_wait);
         wcnt++;
      end
   end

   always @(negedge clk) begin
      if (if_valid) if_done++;
      if (dm_valid) dm_done++;
   end

   always @(negedge clk) begin
      if (mem_req) run++;
      else begin
         if (run != 0) last_len = run;
         run = 0;
      end
      if (if_gnt || dm_gnt) begin
         if (gq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_gnt: got if=%0b dm=%0b expected none", if_gnt, dm_gnt);
         end else begin
            g_m = gq.pop_front();
            chk("gnt_port", {if_gnt, dm_gnt}, {~g_m.dm, g_m.dm});
            chk("gnt_mem_req", mem_req, 1);
            chk("gnt_mem_addr", mem_addr, g_m.addr);
            chk("gnt_mem_we", mem_we, g_m.we);
            chk("gnt_mem_wdata", mem_wdata, g_m.wdata);
         end
         h_addr = mem_addr;
         h_we = mem_we;
         h_wdata = mem_wdata;
      end else if (mem_req) begin
         chk("hold_mem_addr", mem_addr, h_addr);
         chk("hold_mem_we", mem_we, h_we);
         chk("hold_mem_wdata", mem_wdata, h_wdata);
      end
      if (if_valid || dm_valid) begin
         if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got if=%0b dm=%0b expected none", if_valid, dm_valid);
         end else begin
            r_m = rq.pop_front();
            chk("rsp_port", {if_valid, dm_valid}, {~r_m.dm, r_m.dm});
            chk("rsp_rdata", r_m.dm ? dm_rdata : if_rdata, r_m.rdata);
            chk("rsp_bus_err", bus_err, r_m.err);
         end
      end else if (bus_err) chk("stray_bus_err", bus_err, 0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_pulses", {if_gnt, if_valid, dm_gnt, dm_valid, bus_err, cpu_stall, mem_we}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      reset_n = 1;
      @(negedge clk);
      // single fetch, ack in third mem_req cycle
      ack_wait = 2;
      rd_val = 32'h00A00093;
      push_g(0, 32'h40, 0, 0);
      push_r(0, 32'h00A00093, 0);
      start_if(32'h40);
      @(posedge clk);
      #1 chk("fetch_gnt_time", if_gnt, 1);
      chk("stall_while_busy", cpu_stall, 1);
      repeat (3) @(posedge clk);
      #1 chk("fetch_valid_time", if_valid, 1);
      chk("stall_at_valid", cpu_stall, 0);
      @(posedge clk);
      #1 chk("stall_after_valid", cpu_stall, 0);
      chk("fetch_valid_pulse", if_valid, 0);
      wait_done(50);
      // load then store: the store must leave dm_rdata alone
      ack_wait = 1;
      rd_val = 32'hCAFEF00D;
      push_g(1, 32'h104, 0, 0);
      push_r(1, 32'hCAFEF00D, 0);
      start_dm(32'h104, 0, 0);
      wait_done(50);
      ack_wait = 2;
      rd_val = 32'h11111111;
      push_g(1, 32'h100, 1, 32'hDEADBEEF);
      push_r(1, 32'hCAFEF00D, 0);
      start_dm(32'h100, 1, 32'hDEADBEEF);
      wait_done(50);
      chk("store_keeps_rdata", dm_rdata, 32'hCAFEF00D);
      // no ack: timeout after TO cycles of mem_req
      ack_wait = -1;
      push_g(1, 32'h200, 0, 0);
      push_r(1, 0, 1);
      start_dm(32'h200, 0, 0);
      wait_done(50);
      chk("timeout_mem_req_len", last_len, TO);
      ack_wait = 0;
      rd_val = 32'h12345678;
      push_g(1, 32'h204, 0, 0);
      push_r(1, 32'h12345678, 0);
      start_dm(32'h204, 0, 0);
      wait_done(50);
      chk("zero_wait_len", last_len, 1);
      // ack in the timeout cycle wins
      ack_wait = TO - 1;
      rd_val = 32'h0BADF00D;
      push_g(0, 32'h80, 0, 0);
      push_r(0, 32'h0BADF00D, 0);
      start_if(32'h80);
      wait_done(50);
      chk("ack_win_len", last_len, TO);
      // reset while DM_BUSY
      ack_wait = -1;
      push_g(1, 32'h300, 0, 0);
      start_dm(32'h300, 0, 0);
      repeat (3) @(posedge clk);
      #3 reset_n = 0;
      #1 chk("rst_mid_mem_req", mem_req, 0);
      chk("rst_mid_no_valid", dm_valid, 0);
      chk("rst_mid_rdata", dm_rdata, 0);
      chk("rst_mid_gnt_seen", gq.size(), 0);
      @(negedge clk);
      ack_wait = 1;
      rd_val = 32'h55AA55AA;
      push_g(1, 32'h300, 0, 0);
      push_r(1, 32'h55AA55AA, 0);
      reset_n = 1;
      wait_done(50);
      // ties, starting from a fresh last-grant pointer
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      ack_wait = 0;
      rd_val = 32'h77;
      push_g(1, 32'h500, 0, 0);
      push_g(0, 32'h600, 0, 0);
      push_r(1, 32'h77, 0);
      push_r(0, 32'h77, 0);
      start_dm(32'h500, 0, 0);
      start_if(32'h600);
      wait_done(50);
      push_g(1, 32'h510, 0, 0);
      push_r(1, 32'h77, 0);
      start_dm(32'h510, 0, 0);
      wait_done(50);
`ifdef MEM_ARB_RR_EN
      push_g(0, 32'h610, 0, 0);
      push_g(1, 32'h520, 0, 0);
      push_r(0, 32'h77, 0);
      push_r(1, 32'h77, 0);
`else
      push_g(1, 32'h520, 0, 0);
      push_g(0, 32'h610, 0, 0);
      push_r(1, 32'h77, 0);
      push_r(0, 32'h77, 0);
`endif
      start_dm(32'h520, 0, 0);
      start_if(32'h610);
      wait_done(50);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
